// File: rtl/polar_encoder.sv
// Polar encoder: maps info bits onto the non-frozen positions of u, then
// runs the x = u * F^{(x)n} butterfly network one stage per clock and
// offers the codeword on a valid/ready output.
module polar_encoder #(
    parameter int N = 32,
    localparam int LOG2N = $clog2(N),
    localparam int KW = $clog2(N + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [N-1:0]  frozen_i,
    input  logic [N-1:0]  info_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [N-1:0]  x_o,
    output logic [KW-1:0] k_o
);

    // Stage counter only needs to reach LOG2N-1; keep at least one bit for N=2.
    localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ENC,
        DONE
    } state_t;

    state_t          state;
    logic [SW-1:0]   stage;
    logic [N-1:0]    x_q;
    logic [N-1:0]    u_map;
    logic [KW-1:0]   k_map;
    logic [N-1:0]    x_next;
    logic [N-1:0]    partner;
    logic [N-1:0]    upper_mask;
    logic            last_stage;

    // Scatter info bits in order onto the non-frozen positions; the running
    // count doubles as K. Info bits beyond K are simply never selected.
    always_comb begin
        u_map = '0;
        k_map = '0;
        for (int j = 0; j < N; j++) begin
            if (!frozen_i[j]) begin
                u_map[j] = info_i[k_map[LOG2N-1:0]];
                k_map = k_map + KW'(1);
            end
        end
    end

    // One butterfly stage: every index with bit s clear absorbs its partner
    // 2^s positions above it.
    always_comb begin
        x_next     = x_q;
        partner    = '0;
        upper_mask = '0;
        for (int s = 0; s < LOG2N; s++) begin
            if (stage == SW'(s)) begin
                partner = x_q >> (1 << s);
                for (int i = 0; i < N; i++) begin
                    upper_mask[i] = ((i & (1 << s)) == 0);
                end
                x_next = x_q ^ (partner & upper_mask);
            end
        end
    end

    assign last_stage = (stage == SW'(LOG2N - 1));
    assign x_o        = x_q;

    // Control FSM with registered handshake outputs; the x register is
    // reused as the in-place butterfly working storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            stage   <= '0;
            x_q     <= '0;
            k_o     <= '0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        x_q     <= u_map;
                        k_o     <= k_map;
                        stage   <= '0;
                        ready_o <= 1'b0;
                        state   <= ENC;
                    end
                end
                ENC: begin
                    x_q <= x_next;
                    if (last_stage) begin
                        stage   <= '0;
                        valid_o <= 1'b1;
                        state   <= DONE;
                    end else begin
                        stage <= stage + SW'(1);
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    stage   <= '0;
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_polar_encoder.sv
// Self-checking bench for polar_encoder: directed N=8 cases, backpressure
// and mid-encode reset on an N=8 instance, then random N=32 blocks against
// a reference model built directly from the generator-matrix definition.
module tb_polar_encoder;

    logic clk;
    logic rst_n;

    logic       v8_in, r8_out, v8_out, r8_in;
    logic [7:0] fr8, inf8, x8;
    logic [3:0] k8;

    logic        v32_in, r32_out, v32_out, r32_in;
    logic [31:0] fr32, inf32, x32;
    logic [5:0]  k32;

    int checks;
    int fails;

    polar_encoder #(.N(8)) dut8 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (v8_in),
        .ready_o (r8_out),
        .frozen_i(fr8),
        .info_i  (inf8),
        .valid_o (v8_out),
        .ready_i (r8_in),
        .x_o     (x8),
        .k_o     (k8)
    );

    polar_encoder #(.N(32)) dut32 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (v32_in),
        .ready_o (r32_out),
        .frozen_i(fr32),
        .info_i  (inf32),
        .valid_o (v32_out),
        .ready_i (r32_in),
        .x_o     (x32),
        .k_o     (k32)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something never terminates
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: u from the frozen mask, x[j] = XOR of u[i] over every i
    // whose bit set contains j (rows of F^{(x)n}).
    function automatic void encodeModel(input logic [31:0] fr, input logic [31:0] info,
                                        input int n, output logic [31:0] x, output int k);
        logic [31:0] u;
        int c;
        u = '0;
        c = 0;
        for (int j = 0; j < n; j++) begin
            if (!fr[j]) begin
                u[j] = info[c];
                c++;
            end
        end
        x = '0;
        for (int j = 0; j < n; j++)
            for (int i = 0; i < n; i++)
                if (((i & j) == j) && u[i]) x[j] = ~x[j];
        k = c;
    endfunction

    // Wait for ready, present one block for a single edge, then scramble
    // the inputs to show they need not be held.
    task automatic applyStimulus(input bit big, input logic [31:0] fr, input logic [31:0] info);
        int cyc;
        cyc = 0;
        while (!(big ? r32_out : r8_out) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput(big ? "ready32_wait" : "ready8_wait", big ? r32_out : r8_out, 1);
        if (big) begin
            v32_in = 1'b1; fr32 = fr; inf32 = info;
        end else begin
            v8_in = 1'b1; fr8 = fr[7:0]; inf8 = info[7:0];
        end
        @(posedge clk); #1;
        if (big) begin
            v32_in = 1'b0; fr32 = $urandom; inf32 = $urandom;
        end else begin
            v8_in = 1'b0; fr8 = 8'($urandom); inf8 = 8'($urandom);
        end
    endtask

    task automatic runDirected8(input string tag, input logic [7:0] fr, input logic [7:0] info,
                                input logic [7:0] ex, input logic [3:0] ek);
        int cyc;
        applyStimulus(1'b0, {24'd0, fr}, {24'd0, info});
        cyc = 0;
        while (!v8_out && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput({tag, "_latency"}, cyc, 3);
        checkOutput({tag, "_x"}, x8, ex);
        checkOutput({tag, "_k"}, k8, ek);
        @(posedge clk); #1;
        checkOutput({tag, "_back_idle"}, {r8_out, v8_out}, 2'b10);
    endtask

    initial begin
        logic [31:0] fr, info, ex;
        int ek, cyc, first, done;

        checks = 0;
        fails  = 0;
        rst_n  = 1'b0;
        v8_in  = 1'b0; fr8 = '0; inf8 = '0; r8_in = 1'b1;
        v32_in = 1'b0; fr32 = '0; inf32 = '0; r32_in = 1'b0;

        #12;
        checkOutput("rst8_hs", {r8_out, v8_out}, 2'b10);
        checkOutput("rst8_x", x8, 0);
        checkOutput("rst8_k", k8, 0);
        checkOutput("rst32_hs", {r32_out, v32_out}, 2'b10);
        checkOutput("rst32_xk", {x32, 2'b00, k32}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] directed N=8 cases");
        runDirected8("all_info_top", 8'h00, 8'h80, 8'hFF, 4'd8);
        runDirected8("low_nibble", 8'h00, 8'h0F, 8'h08, 4'd8);
        runDirected8("single_lsb", 8'h00, 8'h01, 8'h01, 4'd8);
        runDirected8("frozen_low", 8'h0F, 8'h01, 8'h11, 4'd4);
        runDirected8("frozen_low_upper", 8'h0F, 8'hF1, 8'h11, 4'd4);
        runDirected8("all_frozen", 8'hFF, 8'hA5, 8'h00, 4'd0);

        $display("[TB] backpressure in DONE");
        r8_in = 1'b0;
        applyStimulus(1'b0, 32'h0F, 32'hF1);
        cyc = 0;
        while (!v8_out && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("bp_valid", v8_out, 1);
        for (int t = 0; t < 5; t++) begin
            v8_in = 1'b1; fr8 = 8'($urandom); inf8 = 8'($urandom);
            @(posedge clk); #1;
            checkOutput("bp_hold_hs", {r8_out, v8_out}, 2'b01);
            checkOutput("bp_hold_x", x8, 8'h11);
            checkOutput("bp_hold_k", k8, 4);
        end
        v8_in = 1'b0;
        r8_in = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release", {r8_out, v8_out}, 2'b10);

        $display("[TB] reset during encode");
        applyStimulus(1'b0, 32'h00, 32'h80);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_hs", {r8_out, v8_out}, 2'b10);
        checkOutput("mid_rst_x", x8, 0);
        checkOutput("mid_rst_k", k8, 0);
        #2;
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        checkOutput("mid_rst_no_emit", {r8_out, v8_out}, 2'b10);

        $display("[TB] random N=32 blocks");
        for (int v = 0; v < 1000; v++) begin
            case ($urandom_range(0, 9))
                0: fr = 32'h0;
                1: fr = 32'hFFFF_FFFF;
                2: fr = $urandom & $urandom;
                default: fr = $urandom;
            endcase
            info = $urandom;
            encodeModel(fr, info, 32, ex, ek);
            applyStimulus(1'b1, fr, info);
            cyc = 0;
            first = -1;
            done = 0;
            while (!done && cyc < 200) begin
                r32_in = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) begin
                    v32_in = 1'b1; fr32 = $urandom; inf32 = $urandom;
                end else begin
                    v32_in = 1'b0;
                end
                checkOutput("rnd_busy", r32_out, 0);
                if (v32_out) begin
                    if (first < 0) first = cyc;
                    checkOutput("rnd_x", x32, ex);
                    checkOutput("rnd_k", k32, ek);
                    if (r32_in) done = 1;
                end
                @(posedge clk); #1;
                cyc++;
            end
            v32_in = 1'b0;
            checkOutput("rnd_done", done, 1);
            checkOutput("rnd_latency", first, 5);
            checkOutput("rnd_back_idle", {r32_out, v32_out}, 2'b10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
